// File: rtl/farrow_strobe_interp_pkg.sv
// Timing-recovery shared definitions: mu scaling, Q1.15 limits and the
// rounding/saturation helpers used by the NCO, ZCTED and interpolator.
package farrow_strobe_interp_pkg;

    localparam int MU_ONE    = 512;
    localparam int MU_MAX    = 511;
    localparam int FRAC_BITS = 9;
    localparam int Q15_MAX   = 32767;
    localparam int Q15_MIN   = -32768;

    // Round half up, then drop the mu fraction bits.
    function automatic logic signed [20:0] round_shift(input logic signed [29:0] p);
        logic signed [29:0] r;
        r = (p + (30'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
        return r[20:0];
    endfunction

    function automatic logic signed [15:0] sat_q15(input logic signed [20:0] v);
        if (v > 21'(Q15_MAX))
            return 16'sh7FFF;
        else if (v < 21'(Q15_MIN))
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/farrow_strobe_interp_coef.sv
// Parabolic (alpha = 0.5) Farrow coefficients from four taps, one register stage;
// loads only when i_en is set, no backpressure.
module farrow_coef #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_x0,
    input  logic signed [DATA_W-1:0] i_x1,
    input  logic signed [DATA_W-1:0] i_x2,
    input  logic signed [DATA_W-1:0] i_x3,
    output logic signed [DATA_W+1:0] o_v0,
    output logic signed [DATA_W+1:0] o_v1,
    output logic signed [DATA_W+1:0] o_v2
);

    logic signed [DATA_W+2:0] w_s2;
    logic signed [DATA_W+2:0] w_s1;

    // Sums carry one guard bit so the halving never overflows.
    assign w_s2 = (DATA_W+3)'(i_x0) - (DATA_W+3)'(i_x1)
                - (DATA_W+3)'(i_x2) + (DATA_W+3)'(i_x3);
    assign w_s1 = ((DATA_W+3)'(i_x1) <<< 1) + (DATA_W+3)'(i_x1)
                - (DATA_W+3)'(i_x0) - (DATA_W+3)'(i_x2) - (DATA_W+3)'(i_x3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_v0 <= '0;
            o_v1 <= '0;
            o_v2 <= '0;
        end else if (i_en) begin
            o_v0 <= (DATA_W+2)'(i_x2);
            o_v1 <= w_s1[DATA_W+2:1];
            o_v2 <= w_s2[DATA_W+2:1];
        end
    end

endmodule

// File: rtl/farrow_strobe_interp.sv
// Strobe-driven piecewise-parabolic interpolator, one output per x_valid&strobe event;
// 3 clk event-to-y_valid, fully pipelined, accepts an event every cycle, no backpressure.
module farrow_strobe_interp
    import farrow_strobe_interp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MU_WIDTH = 10,
    parameter int MU_FRAC  = 9,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     x_valid,
    input  logic [MU_WIDTH-1:0]      mu,
    input  logic                     strobe,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_valid,
    output logic [CNT_W-1:0]         sym_count,
    output logic                     mu_clip
);

    logic signed [DATA_W-1:0] r_x0, r_x1, r_x2;
    logic                     w_event;
    logic                     w_clip;

    logic                     r_vld1;
    logic [MU_WIDTH-1:0]      r_mu1;
    logic signed [DATA_W+1:0] w_v0, w_v1, w_v2;

    logic                     r_vld2;
    logic [MU_WIDTH-1:0]      r_mu2;
    logic signed [DATA_W+2:0] r_t;
    logic signed [DATA_W+1:0] r_v0_2;

    logic signed [20:0]       w_p_rs;
    logic signed [20:0]       w_t;
    logic signed [20:0]       w_q_rs;
    logic signed [20:0]       w_y;

    assign w_event = x_valid & strobe;
    assign w_clip  = (mu >> MU_FRAC) != '0;

    // Taps include the sample arriving with the event, so the window is
    // {x_in, x0, x1, x2} before the shift lands.
    farrow_coef #(.DATA_W(DATA_W)) u_coef (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_event),
        .i_x0 (x_in),
        .i_x1 (r_x0),
        .i_x2 (r_x1),
        .i_x3 (r_x2),
        .o_v0 (w_v0),
        .o_v1 (w_v1),
        .o_v2 (w_v2)
    );

    // Horner evaluation: t = v2*mu + v1, y = t*mu + v0; mu is unsigned.
    assign w_p_rs = round_shift(30'(w_v2) * 30'($signed({1'b0, r_mu1})));
    assign w_t    = w_p_rs + 21'(w_v1);
    assign w_q_rs = round_shift(30'(r_t) * 30'($signed({1'b0, r_mu2})));
    assign w_y    = w_q_rs + 21'(r_v0_2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_vld1    <= 1'b0;
            r_mu1     <= '0;
            mu_clip   <= 1'b0;
            r_vld2    <= 1'b0;
            r_mu2     <= '0;
            r_t       <= '0;
            r_v0_2    <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            sym_count <= '0;
        end else begin
            if (x_valid) begin
                r_x0 <= x_in;
                r_x1 <= r_x0;
                r_x2 <= r_x1;
            end

            r_vld1  <= w_event;
            mu_clip <= w_event & w_clip;
            if (w_event)
                r_mu1 <= w_clip ? MU_WIDTH'(MU_MAX) : mu;

            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_t    <= w_t[DATA_W+2:0];
                r_v0_2 <= w_v0;
                r_mu2  <= r_mu1;
            end

            y_valid <= r_vld2;
            if (r_vld2) begin
                y_out     <= sat_q15(w_y);
                sym_count <= sym_count + 1'b1;
            end
        end
    end

endmodule
